// File: rtl/sobel_window_gen.sv
`timescale 1ns/1ps
// sobel_window_gen: raster-order pixel stream in, 3x3 neighbourhoods out for the sobel stage.
// Latency: a window appears one cycle after the pixel that completes it is accepted.
// Backpressure: single output register; in_ready = !out_valid | out_ready, so a full-rate stream has no bubbles.
// Ports: clk; reset (async, active-low); in_valid/in_ready/in_data/in_sof accept one pixel per transfer;
//        out_valid/out_ready/win/out_col/out_row present one window and its centre coordinate per transfer;
//        frame_done pulses for one cycle after the last window of a frame has transferred.
module sobel_window_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_sof,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [9*DATA_W-1:0]        win,
   output logic [$clog2(IMG_W)-1:0]   out_col,
   output logic [$clog2(IMG_H)-1:0]   out_row,
   output logic                       frame_done
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [COL_W-1:0] COL_FD   = COL_W'(IMG_W - 2);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [ROW_W-1:0] ROW_FD   = ROW_W'(IMG_H - 2);

   // Line buffers: lbuf0 holds the previous row, lbuf1 the row before that.
   logic [DATA_W-1:0] lbuf0 [IMG_W];
   logic [DATA_W-1:0] lbuf1 [IMG_W];

   // Column shift registers; index 0 = oldest row, 2 = newest row.
   // col_a is the leftmost (oldest) column of the window, col_b the middle one.
   logic [2:0][DATA_W-1:0] col_a_q, col_a_d;
   logic [2:0][DATA_W-1:0] col_b_q, col_b_d;

   logic [COL_W-1:0]       col_q, col_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic                   out_valid_q, out_valid_d;
   logic [9*DATA_W-1:0]    win_q, win_d;
   logic [COL_W-1:0]       out_col_q, out_col_d;
   logic [ROW_W-1:0]       out_row_q, out_row_d;
   logic                   frame_done_q, frame_done_d;

   logic                   accept;
   logic                   emit;
   logic [COL_W-1:0]       col_cur;
   logic [ROW_W-1:0]       row_cur;
   logic [2:0][DATA_W-1:0] new_col;

   assign in_ready   = !out_valid_q | out_ready;
   assign out_valid  = out_valid_q;
   assign win        = win_q;
   assign out_col    = out_col_q;
   assign out_row    = out_row_q;
   assign frame_done = frame_done_q;

   // Position of the pixel being offered; in_sof forces it to (0,0).
   always_comb begin
      accept     = in_valid & in_ready;
      col_cur    = in_sof ? '0 : col_q;
      row_cur    = in_sof ? '0 : row_q;
      new_col[0] = lbuf1[col_cur];
      new_col[1] = lbuf0[col_cur];
      new_col[2] = in_data;
      // At col>=2 both shift-register columns were loaded in the current row,
      // so a window never mixes in the tail of the previous row.
      emit       = accept && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      col_a_d      = col_a_q;
      col_b_d      = col_b_q;
      out_valid_d  = out_valid_q;
      win_d        = win_q;
      out_col_d    = out_col_q;
      out_row_d    = out_row_q;
      frame_done_d = out_valid_q & out_ready & (out_row_q == ROW_FD) & (out_col_q == COL_FD);

      if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (col_cur == COL_LAST) begin
            col_d = '0;
            row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_ONE;
         end else begin
            col_d = col_cur + COL_ONE;
            row_d = row_cur;
         end
         col_a_d = col_b_q;
         col_b_d = new_col;
      end

      if (emit) begin
         for (int r = 0; r < 3; r++) begin
            win_d[DATA_W*(3*r+0) +: DATA_W] = col_a_q[r];
            win_d[DATA_W*(3*r+1) +: DATA_W] = col_b_q[r];
            win_d[DATA_W*(3*r+2) +: DATA_W] = new_col[r];
         end
         out_col_d   = col_cur - COL_ONE;
         out_row_d   = row_cur - ROW_ONE;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q        <= '0;
         row_q        <= '0;
         col_a_q      <= '0;
         col_b_q      <= '0;
         out_valid_q  <= 1'b0;
         win_q        <= '0;
         out_col_q    <= '0;
         out_row_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         col_a_q      <= col_a_d;
         col_b_q      <= col_b_d;
         out_valid_q  <= out_valid_d;
         win_q        <= win_d;
         out_col_q    <= out_col_d;
         out_row_q    <= out_row_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffers carry no reset: rows 0-1 of every frame rewrite them before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         lbuf0[col_cur] <= in_data;
         lbuf1[col_cur] <= lbuf0[col_cur];
      end
   end

endmodule

// File: tb/tb_sobel_window_gen.sv
`timescale 1ns/1ps
// tb_sobel_window_gen: scoreboard bench for sobel_window_gen on a 4x4 and a 5x3 instance.
// Latency: expected windows are queued at accept time and popped by an independent monitor.
// Backpressure: out_ready is held, stalled for fixed spans, or randomised per test.
module tb_sobel_window_gen;
   localparam int DW = 8;
   localparam int WW = 9 * DW;

   typedef struct {
      logic [WW-1:0] win;
      int            col;
      int            row;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          sel;      // 0 selects the 4x4 instance, 1 the 5x3 instance
   logic          v_in, v_sof, out_rdy;
   logic [DW-1:0] v_dat;

   logic          a_ir, a_ov, a_fd;
   logic [WW-1:0] a_win;
   logic [1:0]    a_col, a_row;
   logic          b_ir, b_ov, b_fd;
   logic [WW-1:0] b_win;
   logic [2:0]    b_col;
   logic [1:0]    b_row;

   sobel_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut_a (
      .clk(clk), .reset(reset),
      .in_valid(v_in & ~sel), .in_data(v_dat), .in_sof(v_sof & ~sel), .in_ready(a_ir),
      .out_valid(a_ov), .out_ready(out_rdy | sel), .win(a_win),
      .out_col(a_col), .out_row(a_row), .frame_done(a_fd)
   );

   sobel_window_gen #(.DATA_W(DW), .IMG_W(5), .IMG_H(3)) u_dut_b (
      .clk(clk), .reset(reset),
      .in_valid(v_in & sel), .in_data(v_dat), .in_sof(v_sof & sel), .in_ready(b_ir),
      .out_valid(b_ov), .out_ready(out_rdy | ~sel), .win(b_win),
      .out_col(b_col), .out_row(b_row), .frame_done(b_fd)
   );

   logic          m_ir, m_ov, m_fd;
   logic [WW-1:0] m_win;
   int            m_col, m_row;
   always_comb begin
      m_ir  = sel ? b_ir  : a_ir;
      m_ov  = sel ? b_ov  : a_ov;
      m_fd  = sel ? b_fd  : a_fd;
      m_win = sel ? b_win : a_win;
      m_col = sel ? int'(b_col) : int'(a_col);
      m_row = sel ? int'(b_row) : int'(a_row);
   end

   // Reference model: a 2D image written in raster order; every pixel at
   // row>=2, col>=2 yields the 3x3 block ending at it.
   int            img [8][8];
   int            pr, pc, cur_w, cur_h;
   exp_t          exp_q [$];
   logic [WW-1:0] popped [$];
   int            fd_cnt;
   int            n_tests, n_fail;
   logic          mon_en;

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic model_accept(input logic [DW-1:0] d, input logic sof);
      exp_t e;
      if (sof) begin
         pr = 0;
         pc = 0;
      end
      img[pr][pc] = int'(d);
      if (pr >= 2 && pc >= 2) begin
         e.win = '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               e.win[DW*(3*r+c) +: DW] = DW'(img[pr-2+r][pc-2+c]);
         e.col = pc - 1;
         e.row = pr - 1;
         exp_q.push_back(e);
      end
      pc++;
      if (pc == cur_w) begin
         pc = 0;
         pr++;
         if (pr == cur_h) pr = 0;
      end
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the pixel.
   task automatic send_pixel(input logic [DW-1:0] d, input logic sof);
      int t;
      t = 0;
      v_in  = 1'b1;
      v_dat = d;
      v_sof = sof;
      forever begin
         @(negedge clk);
         if (m_ir) break;
         t++;
         if (t > 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
            break;
         end
      end
      if (t <= 100) model_accept(d, sof);
      @(posedge clk);
      #1;
      v_in  = 1'b0;
      v_sof = 1'b0;
   endtask

   task automatic drain(input string name, input int base, input int exp_n, input int fd_base, input int exp_fd);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_ov) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      @(negedge clk);
      @(posedge clk);
      #1;
      check({name, "_queue_empty"}, WW'(exp_q.size()), '0);
      check({name, "_window_count"}, WW'(popped.size() - base), WW'(exp_n));
      check({name, "_frame_done_count"}, WW'(fd_cnt - fd_base), WW'(exp_fd));
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard.
   initial begin : monitor
      logic          fd_exp, stalled;
      logic [WW-1:0] h_win;
      int            h_col, h_row;
      exp_t          e;
      fd_exp  = 1'b0;
      stalled = 1'b0;
      h_win   = '0;
      h_col   = 0;
      h_row   = 0;
      fd_cnt  = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            fd_exp  = 1'b0;
            stalled = 1'b0;
         end else begin
            if (m_fd) fd_cnt++;
            if (fd_exp || m_fd) check("frame_done", WW'(m_fd), WW'(fd_exp));
            fd_exp = 1'b0;
            if (stalled) begin
               check("stall_hold_win", m_win, h_win);
               check("stall_hold_pos", WW'({m_ov, m_col, m_row}), WW'({1'b1, h_col, h_row}));
            end
            stalled = 1'b0;
            if (m_ov && out_rdy) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_window: got win %0h at (%0d,%0d), required none", m_win, m_row, m_col);
               end else begin
                  e = exp_q.pop_front();
                  check("win", m_win, e.win);
                  check("centre", WW'({m_row, m_col}), WW'({e.row, e.col}));
                  popped.push_back(m_win);
                  if (e.row == cur_h - 2 && e.col == cur_w - 2) fd_exp = 1'b1;
               end
            end else if (m_ov && !out_rdy) begin
               check("stall_in_ready", WW'(m_ir), '0);
               h_win   = m_win;
               h_col   = m_col;
               h_row   = m_row;
               stalled = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int            base, fdb;
      logic          done;
      logic [WW-1:0] exp_w;
      logic [DW-1:0] newf [16];
      reset   = 1'b0;
      sel     = 1'b0;
      v_in    = 1'b0;
      v_sof   = 1'b0;
      v_dat   = '0;
      out_rdy = 1'b1;
      mon_en  = 1'b0;
      cur_w   = 4;
      cur_h   = 4;
      pr      = 0;
      pc      = 0;
      n_tests = 0;
      n_fail  = 0;

      #12;
      check("reset_outputs", WW'({m_ov, m_fd, m_col, m_row}), '0);
      check("reset_win", m_win, '0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_in_ready", WW'(m_ir), WW'(1));
      mon_en = 1'b1;

      // Test 1: 4x4 ramp, full rate.
      base = popped.size();
      fdb  = fd_cnt;
      for (int i = 0; i < 16; i++) send_pixel(DW'(16*(i/4) + i%4), i == 0);
      drain("t1", base, 4, fdb, 1);
      exp_w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) exp_w[DW*(3*r+c) +: DW] = DW'(16*r + c);
      if (popped.size() > base) check("t1_first_win", popped[base], exp_w);

      // Test 2: same frame, output stalled for 3 cycles while a window is held.
      base = popped.size();
      fdb  = fd_cnt;
      for (int i = 0; i < 16; i++) begin
         if (i == 11) begin
            out_rdy = 1'b0;
            fork
               send_pixel(DW'(16*(i/4) + i%4), 1'b0);
               begin
                  repeat (3) @(posedge clk);
                  #1;
                  out_rdy = 1'b1;
               end
            join
         end else begin
            send_pixel(DW'(16*(i/4) + i%4), i == 0);
         end
      end
      drain("t2", base, 4, fdb, 1);
      for (int k = 0; k < 4; k++)
         if (popped.size() >= base + 4) check("t2_same_sequence", popped[base+k], popped[base-4+k]);

      // Test 3: 5x3 frame with random input gaps and random output backpressure.
      sel   = 1'b1;
      cur_w = 5;
      cur_h = 3;
      pr    = 0;
      pc    = 0;
      base  = popped.size();
      fdb   = fd_cnt;
      done  = 1'b0;
      fork
         begin
            for (int i = 0; i < 15; i++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               send_pixel(DW'($urandom), i == 0);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_rdy = ($urandom_range(0, 3) != 0);
            end
            out_rdy = 1'b1;
         end
      join
      drain("t3", base, 3, fdb, 1);

      // Test 4: in_sof at pixel (2,1) of a partial frame, then a clean 4x4 frame.
      sel   = 1'b0;
      cur_w = 4;
      cur_h = 4;
      pr    = 0;
      pc    = 0;
      base  = popped.size();
      fdb   = fd_cnt;
      for (int i = 0; i < 9; i++) send_pixel(DW'($urandom), i == 0);
      for (int i = 0; i < 16; i++) begin
         newf[i] = DW'($urandom);
         send_pixel(newf[i], i == 0);
      end
      drain("t4", base, 4, fdb, 1);
      exp_w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) exp_w[DW*(3*r+c) +: DW] = newf[4*r + c];
      if (popped.size() > base) check("t4_first_win", popped[base], exp_w);

      // Test 5: reset pulse mid-frame while a window is held, then a full frame without in_sof.
      for (int i = 0; i < 10; i++) send_pixel(DW'($urandom), i == 0);
      out_rdy = 1'b0;
      send_pixel(DW'($urandom), 1'b0);
      mon_en = 1'b0;
      #1;
      reset = 1'b0;
      #0.5;
      check("midrst_outputs", WW'({m_ov, m_fd, m_col, m_row}), '0);
      check("midrst_win", m_win, '0);
      #0.5;
      reset = 1'b1;
      exp_q.delete();
      pr      = 0;
      pc      = 0;
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      base   = popped.size();
      fdb    = fd_cnt;
      for (int i = 0; i < 16; i++) send_pixel(DW'($urandom), 1'b0);
      drain("t5", base, 4, fdb, 1);

      // Test 6: two back-to-back frames with no in_sof; counters must wrap.
      base = popped.size();
      fdb  = fd_cnt;
      for (int i = 0; i < 32; i++) send_pixel(DW'($urandom), 1'b0);
      drain("t6", base, 8, fdb, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
